// File: rtl/wb_ctrl.sv
// Register-file write-back controller: merges single-cycle ALU results with a
// FIFO of long-latency results and tracks outstanding long writes in a scoreboard.
module wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_i,
    input  logic        lng_valid_i,
    input  logic [4:0]  lng_rd_i,
    input  logic [31:0] lng_wdata_i,
    output logic        lng_ready_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic        busy1_o,
    output logic        busy2_o,
    output logic        err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]    fifo_rd_r   [DEPTH];
    logic [31:0]   fifo_data_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   sb_r;
    logic          err_r;

    logic          alu_load_s;
    logic          push_s;
    logic          pop_s;
    logic [4:0]    head_rd_s;
    logic [31:0]   head_data_s;
    logic [31:0]   set_s;
    logic [31:0]   clr_s;
    logic [31:0]   sb_next_s;
    logic          err_next_s;
    logic [CW-1:0] count_next_s;
    logic          we_next_s;
    logic [4:0]    waddr_next_s;
    logic [31:0]   wdata_next_s;

    // Ready depends only on the registered count, never on lng_valid_i.
    assign lng_ready_o = (count_r < CW'(DEPTH));
    assign busy1_o     = sb_r[raddr1_i];
    assign busy2_o     = sb_r[raddr2_i];
    assign err_o       = err_r;
    assign head_rd_s   = fifo_rd_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    // Arbitration, scoreboard update, error detection and output-stage selection.
    always_comb begin
        alu_load_s   = ex_we_i && (ex_waddr_i != 5'd0);
        push_s       = lng_valid_i && lng_ready_o && (lng_rd_i != 5'd0);
        pop_s        = !alu_load_s && (count_r != {CW{1'b0}});
        set_s        = 32'd0;
        clr_s        = 32'd0;
        we_next_s    = 1'b0;
        waddr_next_s = waddr_o;
        wdata_next_s = wdata_o;
        count_next_s = count_r;

        if (iss_valid_i && (iss_rd_i != 5'd0)) begin
            set_s = 32'd1 << iss_rd_i;
        end else begin
            set_s = 32'd0;
        end

        if (alu_load_s) begin
            we_next_s    = 1'b1;
            waddr_next_s = ex_waddr_i;
            wdata_next_s = ex_wdata_i;
        end else if (pop_s) begin
            we_next_s    = 1'b1;
            waddr_next_s = head_rd_s;
            wdata_next_s = head_data_s;
            clr_s        = 32'd1 << head_rd_s;
        end else begin
            we_next_s    = 1'b0;
        end

        // A set in the same cycle as a clear of the same bit wins.
        sb_next_s = ((sb_r & ~clr_s) | set_s) & 32'hFFFF_FFFE;

        err_next_s = err_r
            || (iss_valid_i && (iss_rd_i != 5'd0) && sb_r[iss_rd_i] && !clr_s[iss_rd_i])
            || (alu_load_s && sb_r[ex_waddr_i])
            || (lng_valid_i && lng_ready_o && (lng_rd_i != 5'd0) && !sb_r[lng_rd_i]);

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Control state: pointers, count, scoreboard, sticky error, output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            sb_r     <= 32'd0;
            err_r    <= 1'b0;
            we_o     <= 1'b0;
            waddr_o  <= 5'd0;
            wdata_o  <= 32'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            sb_r    <= sb_next_s;
            err_r   <= err_next_s;
            we_o    <= we_next_s;
            waddr_o <= waddr_next_s;
            wdata_o <= wdata_next_s;
        end
    end

    // FIFO storage needs no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= lng_rd_i;
            fifo_data_r[wr_ptr_r] <= lng_wdata_i;
        end
    end

endmodule

// File: doc/wb_ctrl.md
WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 2: long-result FIFO entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 ex_we_i  in  1  single-cycle (ALU) result valid this cycle.
REQ-005 ex_waddr_i  in  5  ALU destination register.
REQ-006 ex_wdata_i  in  32  ALU result.
REQ-007 iss_valid_i  in  1  long-latency op (load/div) issued this cycle.
REQ-008 iss_rd_i  in  5  destination of the issued long op.
REQ-009 lng_valid_i  in  1  long-latency result offered.
REQ-010 lng_rd_i  in  5  long result destination.
REQ-011 lng_wdata_i  in  32  long result data.
REQ-012 lng_ready_o  out  1  FIFO can accept; transfer = lng_valid_i & lng_ready_o.
REQ-013 we_o / waddr_o / wdata_o  out  1/5/32  registered write port to the general-purpose register file.
REQ-014 raddr1_i, raddr2_i  in  5 each  decode-stage source registers.
REQ-015 busy1_o, busy2_o  out  1 each  source has an outstanding long write (stall request).
REQ-016 err_o  out  1  sticky protocol-violation flag.

Function
REQ-017 Write port is a registered output stage; it loads every cycle and holds a write for exactly one cycle.
REQ-018 Priority at each edge: (a) ex_we_i with ex_waddr_i!=0 loads the output stage; else (b) non-empty FIFO pops its head into the output stage; else we_o<=0.
REQ-019 ALU write latency 1 cycle; long write latency >=2 cycles (FIFO push, then pop), with no bypass around the FIFO.
REQ-020 ALU write with ex_waddr_i==0: we_o<=0, so a non-empty FIFO may pop that cycle.
REQ-021 Accepted lng transfer with lng_rd_i==0: data is discarded and not pushed.
REQ-022 lng_ready_o = (count < DEPTH), from registered count only, with no combinational path from lng_valid_i.
REQ-023 Push and pop in the same cycle: count unchanged, order preserved (FIFO, pointers wrap modulo DEPTH).
REQ-024 Scoreboard: 32-bit vector sb, with bit 0 hardwired 0.
- Set: iss_valid_i & iss_rd_i!=0.
- Clear: at the edge a popped entry loads the output stage for that rd.
- Set and clear of the same bit in one cycle: set wins.
REQ-025 busyN_o = sb[raddrN_i], combinational; 0 for raddrN_i==0.
  - During the we_o cycle the bit is already clear; the register file bypass supplies the data.
REQ-026 err_o sets (and stays 1 until reset) on any of the following:
  - issue to rd with sb[rd]=1 not being cleared that cycle;
  - ALU write to rd with sb[rd]=1;
  - accepted lng transfer to rd!=0 with sb[rd]=0.
  Normal operation continues after an error.
REQ-027 ALU writes are never back-pressured; when ex_we_i is set every cycle, the FIFO stalls and lng_ready_o drops once full.

Reset
REQ-028 While rst=1, and on its release:
  - we_o=0, waddr_o=0, wdata_o=0;
  - sb=0, FIFO empty (count=0, pointers 0), lng_ready_o=1;
  - busy1_o=busy2_o=0, err_o=0.
REQ-029 Reset asserted mid-operation discards FIFO contents and the outstanding scoreboard immediately (asynchronously), with no write issued.

Verification
REQ-030 ALU path: ex_we_i=1, ex_waddr_i=5, ex_wdata_i=0x1234 -> next cycle we_o=1, waddr_o=5, wdata_o=0x1234, then we_o=0.
REQ-031 Long path and hazard:
  - Issue rd=10; busy1_o=1 for raddr1_i=10 from the next cycle.
  - lng rd=10, data 0xDEADBEEF accepted at cycle T -> we_o=1, waddr_o=10 at T+2.
  - busy1_o=0 in that same cycle.
REQ-032 Collision:
  - Issue rd=7 earlier.
  - Same cycle: ALU rd=3 (0x1) and lng rd=7 (0x2) -> rd3 written first cycle, rd7 the next.
  - rd7 busy until its write.
REQ-033 Back-pressure (DEPTH=2):
  - ALU writes every cycle, three issued long results offered back-to-back -> lng_ready_o=0 after two accepts.
  - After ALU stops, writes drain in order, and no data is lost.
REQ-034 Errors:
  - Issue rd=4 twice without completion -> err_o=1 and stays 1.
  - x0 cases: ALU write to x0 -> no write; lng to x0 -> no write; neither sets err_o.
REQ-035 Reset mid-flight: assert rst with FIFO holding 2 entries -> lng_ready_o=1, sb=0, and no write after release.
